// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, ACC, 16-entry register file, ALU and Z/C flags for the course CPU.
// Build option: define CPU_DP_BRANCH_GATE_EN to have the datapath qualify LoadPC with z/c by opcode.
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              LoadAcc,
    input  logic [1:0]        SelAcc,
    input  logic [3:0]        SelALU,
    input  logic [7:0]        imem_data,
    output logic [PC_W-1:0]   imem_addr,
    output logic [3:0]        op,
    output logic              z,
    output logic              c,
    output logic [DATA_W-1:0] acc_out
);
    localparam int EXT_W = (DATA_W > PC_W) ? DATA_W : PC_W;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0] rf_q [16];

    logic [3:0]        rs;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] aluRes;
    logic              aluCarry;
    logic              aluCarryUpd;
    logic [DATA_W:0]   wide;
    logic [EXT_W-1:0]  rsExt;
    logic [PC_W-1:0]   jumpTarget;
    logic              branchOk;

    assign rs         = ir_q[3:0];
    assign rsVal      = rf_q[rs];
    assign rsExt      = EXT_W'(rsVal);
    assign jumpTarget = SelPC ? rsExt[PC_W-1:0] : PC_W'(rs);

    assign imem_addr = pc_q;
    assign op        = ir_q[7:4];
    assign z         = z_q;
    assign c         = c_q;
    assign acc_out   = acc_q;

    // The extra top bit of the widened add/sub yields carry for ADD and borrow for SUB.
    always_comb begin
        wide        = '0;
        aluRes      = acc_q;
        aluCarry    = c_q;
        aluCarryUpd = 1'b0;
        case (SelALU)
            4'b0001: begin
                wide        = {1'b0, acc_q} + {1'b0, rsVal};
                aluRes      = wide[DATA_W-1:0];
                aluCarry    = wide[DATA_W];
                aluCarryUpd = 1'b1;
            end
            4'b0010: begin
                wide        = {1'b0, acc_q} - {1'b0, rsVal};
                aluRes      = wide[DATA_W-1:0];
                aluCarry    = wide[DATA_W];
                aluCarryUpd = 1'b1;
            end
            4'b0011: aluRes = ~(acc_q | rsVal);
            4'b1011: begin
                aluRes      = {acc_q[DATA_W-2:0], 1'b0};
                aluCarry    = acc_q[DATA_W-1];
                aluCarryUpd = 1'b1;
            end
            4'b1100: begin
                aluRes      = {1'b0, acc_q[DATA_W-1:1]};
                aluCarry    = acc_q[0];
                aluCarryUpd = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CPU_DP_BRANCH_GATE_EN
    always_comb begin
        case (ir_q[7:4])
            4'b0110, 4'b0111: branchOk = z_q;
            4'b1000, 4'b1010: branchOk = c_q;
            default:          branchOk = 1'b1;
        endcase
    end
`else
    assign branchOk = 1'b1;
`endif

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        z_d   = z_q;
        c_d   = c_q;
        if (LoadPC && branchOk) begin
            pc_d = jumpTarget;
        end else if (IncPC) begin
            pc_d = pc_q + PC_W'(1);
        end
        if (LoadIR) begin
            ir_d = imem_data;
        end
        // SelAcc 01 is reserved: neither ACC nor flags move.
        if (LoadAcc && (SelAcc != 2'b01)) begin
            case (SelAcc)
                2'b00: begin
                    acc_d = aluRes;
                    if (aluCarryUpd) begin
                        c_d = aluCarry;
                    end
                end
                2'b10:   acc_d = rsVal;
                default: acc_d = DATA_W'(rs);
            endcase
            z_d = (acc_d == '0);
        end
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            z_q   <= z_d;
            c_q   <= c_d;
            if (LoadReg) begin
                rf_q[rs] <= acc_q;
            end
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// Testbench for cpu_datapath: directed test-plan steps followed by random strobes,
// all checked against a behavioural model of PC, IR, ACC, flags and register file.
module tb_cpu_datapath;
    logic       clk = 1'b0;
    logic       CLB;
    logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [3:0] op;
    logic       z, c;
    logic [7:0] acc_out;

    int vectors = 0;
    int miscompares = 0;

    int mPc, mIr, mAcc, mZ, mC;
    int mR [16];

    cpu_datapath #(.DATA_W(8), .PC_W(8)) dut (
        .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
        .SelALU(SelALU), .imem_data(imem_data), .imem_addr(imem_addr), .op(op),
        .z(z), .c(c), .acc_out(acc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 0; mIr = 0; mAcc = 0; mZ = 0; mC = 0;
        for (int i = 0; i < 16; i++) mR[i] = 0;
    endtask

    // One clock of the architectural rules, evaluated on pre-edge state.
    task automatic modelStep(input int instr, input int lir, input int inc, input int selpc,
                             input int ldpc, input int ldreg, input int ldacc,
                             input int selacc, input int selalu);
        int rs, b, res, cNew, updC, target, cond, nPc, nAcc, nZ, nC;
        rs = mIr % 16;
        b  = mR[rs];
        res = mAcc; cNew = mC; updC = 0;
        case (selalu)
            1:  begin res = (mAcc + b) % 256; cNew = (mAcc + b > 255) ? 1 : 0; updC = 1; end
            2:  begin res = (mAcc - b + 256) % 256; cNew = (mAcc < b) ? 1 : 0; updC = 1; end
            3:  res = 255 - (mAcc | b);
            11: begin res = (mAcc * 2) % 256; cNew = mAcc / 128; updC = 1; end
            12: begin res = mAcc / 2; cNew = mAcc % 2; updC = 1; end
            default: ;
        endcase
        target = selpc ? b : rs;
        cond = 1;
`ifdef CPU_DP_BRANCH_GATE_EN
        if (mIr / 16 == 6 || mIr / 16 == 7) cond = mZ;
        if (mIr / 16 == 8 || mIr / 16 == 10) cond = mC;
`endif
        nPc = mPc;
        if (ldpc && cond) nPc = target;
        else if (inc) nPc = (mPc + 1) % 256;
        nAcc = mAcc; nZ = mZ; nC = mC;
        if (ldacc && selacc != 1) begin
            if (selacc == 0) begin
                nAcc = res;
                if (updC) nC = cNew;
            end else if (selacc == 2) nAcc = b;
            else nAcc = rs;
            nZ = (nAcc == 0) ? 1 : 0;
        end
        if (ldreg) mR[rs] = mAcc;
        if (lir) mIr = instr;
        mPc = nPc; mAcc = nAcc; mZ = nZ; mC = nC;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".pc"},  32'(imem_addr), 32'(mPc));
        check({tag, ".op"},  32'(op),        32'(mIr / 16));
        check({tag, ".acc"}, 32'(acc_out),   32'(mAcc));
        check({tag, ".z"},   32'(z),         32'(mZ));
        check({tag, ".c"},   32'(c),         32'(mC));
    endtask

    task automatic applyStimulus(input string tag, input int instr, input int lir, input int inc,
                                 input int selpc, input int ldpc, input int ldreg, input int ldacc,
                                 input int selacc, input int selalu);
        imem_data = 8'(instr);
        LoadIR = 1'(lir); IncPC = 1'(inc); SelPC = 1'(selpc); LoadPC = 1'(ldpc);
        LoadReg = 1'(ldreg); LoadAcc = 1'(ldacc); SelAcc = 2'(selacc); SelALU = 4'(selalu);
        @(posedge clk);
        modelStep(instr, lir, inc, selpc, ldpc, ldreg, ldacc, selacc, selalu);
        #1;
        checkOutput(tag);
    endtask

    task automatic doInstr(input string tag, input int instr, input int selpc, input int ldpc,
                           input int ldreg, input int ldacc, input int selacc, input int selalu);
        applyStimulus({tag, ".fetch"}, instr, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus({tag, ".exec"}, instr, 0, 0, selpc, ldpc, ldreg, ldacc, selacc, selalu);
    endtask

    task automatic ldim(input int v);
        doInstr("ldim", 8'hD0 | v, 0, 0, 0, 1, 3, 0);
    endtask

    task automatic storeR(input int r);
        doInstr("store", 8'h50 | r, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic addR(input int r);
        doInstr("add", 8'h10 | r, 0, 0, 0, 1, 0, 1);
    endtask

    task automatic loadConst(input int v);
        ldim(v / 16);
        for (int i = 0; i < 4; i++) doInstr("shl", 8'hB0, 0, 0, 0, 1, 0, 11);
        storeR(15);
        ldim(v % 16);
        addR(15);
    endtask

    initial begin
        CLB = 1'b0;
        imem_data = '0;
        LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
        SelAcc = '0; SelALU = '0;
        modelReset();
        #12;
        checkOutput("reset");
        CLB = 1'b1;

        applyStimulus("fetch", 8'hD5, 1, 1, 0, 0, 0, 0, 0, 0);
        check("fetch.op", 32'(op), 32'hD);
        check("fetch.pc", 32'(imem_addr), 32'h1);
        applyStimulus("ldim5", 8'hD5, 0, 0, 0, 0, 0, 1, 3, 0);
        check("ldim5.acc", 32'(acc_out), 32'h05);

        ldim(1); storeR(2);
        loadConst(8'hFF);
        check("const_ff", 32'(acc_out), 32'hFF);
        addR(2);
        check("addovf.acc", 32'(acc_out), 32'h00);
        check("addovf.z", 32'(z), 32'h1);
        check("addovf.c", 32'(c), 32'h1);

        ldim(5); storeR(1); ldim(3);
        doInstr("sub", 8'h21, 0, 0, 0, 1, 0, 2);
        check("sub.acc", 32'(acc_out), 32'hFE);
        check("sub.z", 32'(z), 32'h0);
        check("sub.c", 32'(c), 32'h1);

        ldim(1);
        doInstr("jz_z0", 8'h79, 0, 1, 0, 0, 0, 0);
`ifdef CPU_DP_BRANCH_GATE_EN
        check("jz_z0.pc", 32'(imem_addr), 32'h01);
`else
        check("jz_z0.pc", 32'(imem_addr), 32'h09);
`endif
        ldim(0);
        doInstr("jz_z1", 8'h79, 0, 1, 0, 0, 0, 0);
        check("jz_z1.pc", 32'(imem_addr), 32'h09);

        loadConst(8'h42);
        storeR(3);
        ldim(0);
        doInstr("ldr3", 8'h93, 0, 0, 0, 1, 2, 0);
        check("mova.r3", 32'(acc_out), 32'h42);

        loadConst(8'hFF); storeR(7);
        doInstr("jr7", 8'h07, 1, 1, 0, 0, 0, 0);
        check("jr7.pc", 32'(imem_addr), 32'hFF);
        applyStimulus("wrap", 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        check("wrap.pc", 32'(imem_addr), 32'h00);

        loadConst(8'h23); storeR(8);
        doInstr("jr8", 8'h08, 1, 1, 0, 0, 0, 0);
        loadConst(8'h11); storeR(5);
        loadConst(8'h7F);
        check("pre_rst.pc", 32'(imem_addr), 32'h23);
        check("pre_rst.acc", 32'(acc_out), 32'h7F);
        CLB = 1'b0;
        #2;
        modelReset();
        checkOutput("midreset");
        #2;
        CLB = 1'b1;
        doInstr("ldr5", 8'h05, 0, 0, 0, 1, 2, 0);
        check("midreset.r5", 32'(acc_out), 32'h00);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", int'($urandom_range(255)), int'($urandom_range(1)),
                          int'($urandom_range(1)), int'($urandom_range(1)),
                          int'($urandom_range(3) == 0), int'($urandom_range(1)),
                          int'($urandom_range(1)), int'($urandom_range(3)),
                          int'($urandom_range(15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
